collision_event_scheduler: RTL and testbench

COLLISION_EVENT_SCHEDULER -- requirements
Module: collision_event_scheduler

---
 rtl/collision_event_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_collision_event_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_event_scheduler.sv
// Collects per-frame ball/wall/hole/ball-pair collisions and issues them one at a time over a
// valid/ack handshake. Hole detection and ball pocketing are enabled by COLL_SCHED_HOLE_EN.
module collision_event_scheduler (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       restart,
    input  logic [3:0] drawing_request_Ball,
    input  logic       drawing_request_wall,
    input  logic       drawing_request_hole,
    output logic       event_valid,
    output logic [1:0] event_type,
    output logic [1:0] event_idA,
    output logic [1:0] event_idB,
    input  logic       event_ack,
    output logic [3:0] disable_ball,
    output logic       frame_hit,
    output logic       overrun
);

    // Bit layout, lowest index wins arbitration: [3:0] hole, [9:4] pairs, [13:10] wall.
    localparam int unsigned NumBits = 14;

    typedef enum logic [1:0] {StIdle, StArb, StIssue} state_e;

    state_e             state_q;
    logic [NumBits-1:0] acc_q, acc_d, pend_q, pend_d;
    logic [NumBits-1:0] new_bits, clr_sel, clr_ball, pend_kept, acc_kept, new_kept, snap;
    logic [3:0]         eff_ball, wall_hit, hole_hit, sel_c, sel_q;
    logic [5:0]         pair_hit;
    logic               valid_q, frame_hit_q, overrun_q, ack_fire, hole_ack;
    logic [1:0]         type_q, ida_q, idb_q;

    function automatic logic [NumBits-1:0] ball_mask(input logic [1:0] b);
        logic [NumBits-1:0] m;
        case (b)
            2'd0:    m = 14'b0001_000111_0001;
            2'd1:    m = 14'b0010_011001_0010;
            2'd2:    m = 14'b0100_101010_0100;
            default: m = 14'b1000_110100_1000;
        endcase
        return m;
    endfunction

    // Returns {type, idA, idB} for a pending-bit index.
    function automatic logic [5:0] decode(input logic [3:0] idx);
        logic [5:0] r;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3: r = {2'd2, idx[1:0], idx[1:0]};
            4'd4:    r = {2'd1, 2'd0, 2'd1};
            4'd5:    r = {2'd1, 2'd0, 2'd2};
            4'd6:    r = {2'd1, 2'd0, 2'd3};
            4'd7:    r = {2'd1, 2'd1, 2'd2};
            4'd8:    r = {2'd1, 2'd1, 2'd3};
            4'd9:    r = {2'd1, 2'd2, 2'd3};
            4'd10:   r = {2'd0, 2'd0, 2'd0};
            4'd11:   r = {2'd0, 2'd1, 2'd1};
            4'd12:   r = {2'd0, 2'd2, 2'd2};
            4'd13:   r = {2'd0, 2'd3, 2'd3};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    assign eff_ball = drawing_request_Ball & ~disable_ball;
    assign wall_hit = eff_ball & {4{drawing_request_wall}};
    assign pair_hit = {eff_ball[2] & eff_ball[3], eff_ball[1] & eff_ball[3],
                       eff_ball[1] & eff_ball[2], eff_ball[0] & eff_ball[3],
                       eff_ball[0] & eff_ball[2], eff_ball[0] & eff_ball[1]};
    assign new_bits = {wall_hit, pair_hit, hole_hit};

    assign ack_fire  = valid_q & event_ack;
    assign hole_ack  = ack_fire & (type_q == 2'd2);
    assign clr_sel   = ack_fire ? ({{(NumBits-1){1'b0}}, 1'b1} << sel_q) : '0;
    assign clr_ball  = hole_ack ? ball_mask(ida_q) : '0;
    assign pend_kept = pend_q & ~clr_sel & ~clr_ball;
    assign acc_kept  = acc_q & ~clr_ball;
    assign new_kept  = new_bits & ~clr_ball;
    assign snap      = pend_kept | acc_kept;

    always_comb begin
        sel_c = '0;
        for (int i = int'(NumBits) - 1; i >= 0; i--) begin
            if (pend_q[i]) sel_c = 4'(i);
        end
    end

    // A hit sampled together with startOfFrame seeds the freshly cleared accumulator.
    always_comb begin
        pend_d = pend_kept;
        acc_d  = acc_kept | new_kept;
        if (restart) begin
            pend_d = '0;
            acc_d  = '0;
        end else if (startOfFrame) begin
            pend_d = snap;
            acc_d  = new_kept;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q       <= '0;
            pend_q      <= '0;
            frame_hit_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            pend_q      <= pend_d;
            frame_hit_q <= ~restart & startOfFrame & (|snap);
            overrun_q   <= ~restart & startOfFrame & (|pend_kept);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            type_q  <= 2'd0;
            ida_q   <= 2'd0;
            idb_q   <= 2'd0;
            sel_q   <= 4'd0;
        end else if (restart) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            type_q  <= 2'd0;
            ida_q   <= 2'd0;
            idb_q   <= 2'd0;
            sel_q   <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|pend_q) state_q <= StArb;
                end
                StArb: begin
                    if (!(|pend_q)) begin
                        state_q <= StIdle;
                    end else begin
                        {type_q, ida_q, idb_q} <= decode(sel_c);
                        sel_q   <= sel_c;
                        valid_q <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (event_ack) begin
                        valid_q <= 1'b0;
                        state_q <= StArb;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef COLL_SCHED_HOLE_EN
    logic [3:0] dis_q;

    assign hole_hit = eff_ball & {4{drawing_request_hole}};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dis_q <= 4'b0;
        end else if (restart) begin
            dis_q <= 4'b0;
        end else if (hole_ack) begin
            dis_q <= dis_q | (4'b0001 << ida_q);
        end
    end

    assign disable_ball = dis_q;
`else
    logic unused_hole;

    assign unused_hole  = drawing_request_hole;
    assign hole_hit     = 4'b0;
    assign disable_ball = 4'b0;
`endif

    assign event_valid = valid_q;
    assign event_type  = type_q;
    assign event_idA   = ida_q;
    assign event_idB   = idb_q;
    assign frame_hit   = frame_hit_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_collision_event_scheduler.sv
// Bench for collision_event_scheduler: vector table, directed corner sequences and random
// traffic, all cross-checked every cycle against an event-set reference model.
module tb_collision_event_scheduler;

    localparam bit HoleEn =
`ifdef COLL_SCHED_HOLE_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       sof = 1'b0;
    logic       restart = 1'b0;
    logic [3:0] balls = 4'b0;
    logic       wall = 1'b0;
    logic       hole = 1'b0;
    logic       ack = 1'b0;
    logic       event_valid, frame_hit, overrun;
    logic [1:0] event_type, event_idA, event_idB;
    logic [3:0] disable_ball;

    int checks = 0;
    int failures = 0;

    collision_event_scheduler dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (sof),
        .restart              (restart),
        .drawing_request_Ball (balls),
        .drawing_request_wall (wall),
        .drawing_request_hole (hole),
        .event_valid          (event_valid),
        .event_type           (event_type),
        .event_idA            (event_idA),
        .event_idB            (event_idB),
        .event_ack            (ack),
        .disable_ball         (disable_ball),
        .frame_hit            (frame_hit),
        .overrun              (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: collisions kept as sets indexed [type][idA][idB].
    bit m_acc [3][4][4];
    bit m_pend[3][4][4];
    bit m_dis [4];
    int m_phase;  // 0 waiting for a snapshot, 1 choosing, 2 presenting
    int m_t, m_a, m_b;
    bit m_valid, m_fh, m_ov;

    function automatic bit m_any();
        for (int t = 0; t < 3; t++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    if (m_pend[t][a][b]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_pick(output int t, output int a, output int b);
        t = 0; a = 0; b = 0;
        for (int i = 0; i < 4; i++)
            if (m_pend[2][i][i]) begin t = 2; a = i; b = i; return 1'b1; end
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (m_pend[1][i][j]) begin t = 1; a = i; b = j; return 1'b1; end
        for (int i = 0; i < 4; i++)
            if (m_pend[0][i][i]) begin t = 0; a = i; b = i; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic m_clear();
        for (int t = 0; t < 3; t++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++) begin
                    m_acc[t][a][b]  = 1'b0;
                    m_pend[t][a][b] = 1'b0;
                end
        for (int i = 0; i < 4; i++) m_dis[i] = 1'b0;
        m_phase = 0; m_valid = 1'b0; m_fh = 1'b0; m_ov = 1'b0;
        m_t = 0; m_a = 0; m_b = 0;
    endtask

    task automatic m_step();
        bit nw [3][4][4];
        bit eff[4];
        bit fired, had, found, leftover;
        int st, sa, sb, ft, fa, fb;
        if (restart) begin m_clear(); return; end
        had = m_any();
        found = m_pick(st, sa, sb);
        fired = m_valid && ack;
        ft = m_t; fa = m_a; fb = m_b;
        case (m_phase)
            0: if (had) m_phase = 1;
            1: if (!found) m_phase = 0;
               else begin m_t = st; m_a = sa; m_b = sb; m_valid = 1'b1; m_phase = 2; end
            default: if (fired) begin m_valid = 1'b0; m_phase = 1; end
        endcase
        for (int i = 0; i < 4; i++) eff[i] = balls[i] && !m_dis[i];
        for (int t = 0; t < 3; t++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++) nw[t][a][b] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (eff[i] && wall) nw[0][i][i] = 1'b1;
            if (HoleEn && eff[i] && hole) nw[2][i][i] = 1'b1;
            for (int j = i + 1; j < 4; j++) if (eff[i] && eff[j]) nw[1][i][j] = 1'b1;
        end
        if (fired) begin
            m_pend[ft][fa][fb] = 1'b0;
            if (ft == 2) begin
                m_dis[fa] = 1'b1;
                for (int t = 0; t < 3; t++)
                    for (int a = 0; a < 4; a++)
                        for (int b = 0; b < 4; b++)
                            if (a == fa || b == fa) begin
                                m_pend[t][a][b] = 1'b0;
                                m_acc[t][a][b]  = 1'b0;
                                nw[t][a][b]     = 1'b0;
                            end
            end
        end
        leftover = m_any();
        for (int t = 0; t < 3; t++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++) begin
                    if (sof) begin
                        m_pend[t][a][b] = m_pend[t][a][b] | m_acc[t][a][b];
                        m_acc[t][a][b]  = nw[t][a][b];
                    end else begin
                        m_acc[t][a][b]  = m_acc[t][a][b] | nw[t][a][b];
                    end
                end
        m_fh = sof && m_any();
        m_ov = sof && leftover;
    endtask

    always @(posedge clk or negedge resetN) begin
        if (!resetN) m_clear();
        else m_step();
    end

    always @(negedge clk) begin
        logic [3:0] md;
        bit ok;
        md = {m_dis[3], m_dis[2], m_dis[1], m_dis[0]};
        ok = (event_valid === m_valid) && (disable_ball === md) && (frame_hit === m_fh)
             && (overrun === m_ov);
        if (m_valid)
            ok = ok && (event_type === 2'(m_t)) && (event_idA === 2'(m_a))
                 && (event_idB === 2'(m_b));
        checks++;
        if (!ok) begin
            failures++;
            if (failures <= 20)
                $display("FAIL model_cycle t=%0t actual v=%b ev=%0d,%0d,%0d dis=%b fh=%b ov=%b %s",
                         $time, event_valid, event_type, event_idA, event_idB, disable_ball,
                         frame_hit, overrun,
                         $sformatf("required v=%b ev=%0d,%0d,%0d dis=%b fh=%b ov=%b",
                                   m_valid, m_t, m_a, m_b, md, m_fh, m_ov));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_restart();
        restart = 1'b1; tick(); restart = 1'b0;
    endtask

    task automatic hit(input logic [3:0] bl, input logic w, input logic h);
        balls = bl; wall = w; hole = h; tick();
        balls = 4'b0; wall = 1'b0; hole = 1'b0;
    endtask

    task automatic sof_pulse();
        sof = 1'b1; tick(); sof = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (event_valid !== 1'b1 && k < 30) begin tick(); k++; end
        chk({name, "_valid"}, 16'(event_valid), 16'd1);
    endtask

    task automatic expect_event(input string name, input logic [5:0] ev);
        wait_valid(name);
        chk({name, "_evt"}, 16'({event_type, event_idA, event_idB}), 16'(ev));
        ack = 1'b1; tick(); ack = 1'b0;
        chk({name, "_drop"}, 16'(event_valid), 16'd0);
    endtask

    task automatic quiet(input string name, input int n);
        logic seen = 1'b0;
        for (int k = 0; k < n; k++) begin seen |= event_valid; tick(); end
        chk(name, 16'(seen), 16'd0);
    endtask

    typedef struct {
        logic [3:0] bl;
        logic       w;
        logic       h;
        logic       ev_v;
        logic [5:0] ev;
    } vec_t;

    vec_t       vecs[8];
    logic [5:0] exp_q[$];

    initial begin
        vecs[0] = '{4'b0101, 1'b0, 1'b0, 1'b1, {2'd1, 2'd0, 2'd2}};
        vecs[1] = '{4'b0010, 1'b1, 1'b0, 1'b1, {2'd0, 2'd1, 2'd1}};
        vecs[2] = '{4'b1000, 1'b0, 1'b1, HoleEn, {2'd2, 2'd3, 2'd3}};
        vecs[3] = '{4'b1100, 1'b1, 1'b0, 1'b1, {2'd1, 2'd2, 2'd3}};
        vecs[4] = '{4'b0011, 1'b0, 1'b1, 1'b1,
                    HoleEn ? {2'd2, 2'd0, 2'd0} : {2'd1, 2'd0, 2'd1}};
        vecs[5] = '{4'b0000, 1'b1, 1'b1, 1'b0, 6'd0};
        vecs[6] = '{4'b1111, 1'b0, 1'b0, 1'b1, {2'd1, 2'd0, 2'd1}};
        vecs[7] = '{4'b1001, 1'b1, 1'b0, 1'b1, {2'd1, 2'd0, 2'd3}};

        repeat (3) tick();
        chk("reset_outputs", 16'({event_valid, event_type, event_idA, event_idB, disable_ball,
                                  frame_hit, overrun}), 16'd0);
        resetN = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_restart();
            hit(vecs[i].bl, vecs[i].w, vecs[i].h);
            sof_pulse();
            chk($sformatf("vec%0d_frame_hit", i), 16'(frame_hit), 16'(vecs[i].ev_v));
            chk($sformatf("vec%0d_lat0", i), 16'(event_valid), 16'd0);
            tick();
            chk($sformatf("vec%0d_lat1", i), 16'(event_valid), 16'd0);
            tick();
            chk($sformatf("vec%0d_valid", i), 16'(event_valid), 16'(vecs[i].ev_v));
            if (vecs[i].ev_v)
                chk($sformatf("vec%0d_evt", i), 16'({event_type, event_idA, event_idB}),
                    16'(vecs[i].ev));
            for (int k = 0; k < 40; k++) begin ack = event_valid; tick(); end
            ack = 1'b0;
        end

        // Three collisions in one frame drain in priority order; hole pockets ball 3.
        do_restart();
        hit(4'b0010, 1'b1, 1'b0);
        hit(4'b1000, 1'b0, 1'b1);
        hit(4'b0011, 1'b0, 1'b0);
        sof_pulse();
        exp_q.delete();
        if (HoleEn) exp_q.push_back({2'd2, 2'd3, 2'd3});
        exp_q.push_back({2'd1, 2'd0, 2'd1});
        exp_q.push_back({2'd0, 2'd1, 2'd1});
        for (int k = 0; k < exp_q.size(); k++) begin
            expect_event($sformatf("order%0d", k), exp_q[k]);
            if (k == 0) chk("order_disable", 16'(disable_ball), HoleEn ? 16'h8 : 16'h0);
        end
        quiet("order_no_extra", 6);

        // Ack withheld across a frame boundary: overrun, both events delivered once.
        do_restart();
        hit(4'b0101, 1'b0, 1'b0);
        sof_pulse();
        wait_valid("ovr_old");
        hit(4'b0100, 1'b1, 1'b0);
        sof_pulse();
        chk("ovr_pulse", 16'(overrun), 16'd1);
        chk("ovr_frame_hit", 16'(frame_hit), 16'd1);
        tick();
        chk("ovr_pulse_end", 16'(overrun), 16'd0);
        expect_event("ovr_first", {2'd1, 2'd0, 2'd2});
        expect_event("ovr_second", {2'd0, 2'd2, 2'd2});
        quiet("ovr_no_extra", 8);

        // Hit coincident with startOfFrame belongs to the next frame.
        do_restart();
        balls = 4'b0001; wall = 1'b1;
        sof_pulse();
        balls = 4'b0; wall = 1'b0;
        chk("same_cycle_fh", 16'(frame_hit), 16'd0);
        quiet("same_cycle_none", 5);
        sof_pulse();
        chk("same_cycle_fh2", 16'(frame_hit), 16'd1);
        expect_event("same_cycle", {2'd0, 2'd0, 2'd0});

        // Asynchronous reset while an event is presented.
        do_restart();
        hit(4'b0011, 1'b0, 1'b0);
        sof_pulse();
        wait_valid("rst_pre");
        #2 resetN = 1'b0;
        #1 chk("rst_async", 16'({event_valid, event_type, event_idA, event_idB, disable_ball,
                                 frame_hit, overrun}), 16'd0);
        tick();
        resetN = 1'b1;
        quiet("rst_no_reissue", 6);
        sof_pulse();
        quiet("rst_empty_frame", 4);
        hit(4'b0110, 1'b0, 1'b0);
        sof_pulse();
        expect_event("rst_new", {2'd1, 2'd1, 2'd2});

        // Hole-only traffic: pockets the ball only when hole support is built in.
        do_restart();
        hit(4'b0001, 1'b0, 1'b1);
        sof_pulse();
        for (int k = 0; k < 10; k++) begin ack = event_valid; tick(); end
        ack = 1'b0;
        chk("hole_disable", 16'(disable_ball), HoleEn ? 16'h1 : 16'h0);

        // Random traffic, checked only by the per-cycle model comparison.
        do_restart();
        for (int n = 0; n < 4000; n++) begin
            balls   = 4'($urandom) & 4'($urandom);
            wall    = ($urandom_range(0, 3) == 0);
            hole    = ($urandom_range(0, 5) == 0);
            sof     = ($urandom_range(0, 11) == 0);
            restart = ($urandom_range(0, 199) == 0);
            ack     = ($urandom_range(0, 2) != 0);
            tick();
        end
        balls = 4'b0; wall = 1'b0; hole = 1'b0; sof = 1'b0; restart = 1'b0; ack = 1'b0;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
